// File: rtl/stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
// Shared definitions for the guarded data/return stack.
//   delta_t       : 2-bit signed SP-adjust code driven by the decode stage
//   DELTA_*       : named encodings of that code (+1, 0, -1, -2)
//   delta_to_int  : decodes a delta code (gated by 'change') to a 2-bit
//                   two's-complement step, ready for sign extension
// -----------------------------------------------------------------------------
package stack_pkg;

  typedef logic [1:0] delta_t;

  localparam delta_t DELTA_PUSH = 2'b01;  // +1
  localparam delta_t DELTA_NONE = 2'b00;  //  0
  localparam delta_t DELTA_POP  = 2'b11;  // -1
  localparam delta_t DELTA_POP2 = 2'b10;  // -2

  // The encoding is already two's complement; gating on 'change' is the only
  // work needed. Kept as a function so every user agrees on the gating.
  function automatic logic [1:0] delta_to_int(input delta_t code, input logic change);
    logic [1:0] step;
    step = DELTA_NONE;
    if (change) begin
      unique case (code)
        DELTA_PUSH: step = 2'b01;
        DELTA_POP:  step = 2'b11;
        DELTA_POP2: step = 2'b10;
        default:    step = 2'b00;
      endcase
    end
    return step;
  endfunction

endpackage : stack_pkg

// File: rtl/sp_guard.sv
// -----------------------------------------------------------------------------
// sp_guard
// Purely combinational next-SP / next-depth calculator with range checking.
//   sp       in  SADDR_WIDTH   : current stack pointer (top element)
//   depth    in  SADDR_WIDTH+1 : current occupancy
//   delta    in  2             : signed SP adjust code (stack_pkg::delta_t)
//   change   in  1             : apply delta (else effective delta is 0)
//   update   in  1             : a write is requested at the new SP
//   sp_n     out SADDR_WIDTH   : SP + d, modulo 2**SADDR_WIDTH
//   dep_n    out SADDR_WIDTH+2 : depth + d, two's complement
//   ovf_err  out 1             : dep_n exceeds capacity
//   udf_err  out 1             : dep_n negative, or a write with no element
// -----------------------------------------------------------------------------
module sp_guard
  import stack_pkg::*;
#(
  parameter int SADDR_WIDTH = 8
) (
  input  logic [SADDR_WIDTH-1:0] sp,
  input  logic [SADDR_WIDTH:0]   depth,
  input  logic [1:0]             delta,
  input  logic                   change,
  input  logic                   update,
  output logic [SADDR_WIDTH-1:0] sp_n,
  output logic [SADDR_WIDTH+1:0] dep_n,
  output logic                   ovf_err,
  output logic                   udf_err
);

  // One extra bit above depth so that -2..CAP+1 is representable as signed.
  localparam int DW = SADDR_WIDTH + 2;
  localparam logic [SADDR_WIDTH:0] CAP = {1'b1, {SADDR_WIDTH{1'b0}}};

  logic [1:0]    step;
  logic [DW-1:0] step_ext;
  logic [DW-1:0] depth_ext;

  always_comb begin
    step      = delta_to_int(delta_t'(delta), change);
    step_ext  = {{SADDR_WIDTH{step[1]}}, step};
    depth_ext = {1'b0, depth};
    dep_n     = depth_ext + step_ext;
    // Modulo arithmetic on the low bits gives SP wrap for free.
    sp_n      = sp + step_ext[SADDR_WIDTH-1:0];
    // dep_n[DW-1] is the sign bit: negative results are never overflow.
    ovf_err   = !dep_n[DW-1] && (dep_n[DW-2:0] > CAP);
    udf_err   = dep_n[DW-1] || (update && (dep_n == '0));
  end

endmodule : sp_guard

// File: rtl/stack_guarded.sv
// -----------------------------------------------------------------------------
// stack_guarded
// Parametrised data/return stack for the Forth core: signed multi-step SP
// adjust (-2..+1), top and next-on-stack read ports, occupancy tracking and
// optional overflow/underflow guarding with sticky error flags.
//
// Configuration macro: STACK_GUARD_EN
//   defined   : out-of-range operations are suppressed and flagged (sticky)
//   undefined : every cycle is accepted, SP/depth wrap, flags tied to 0
//
// Ports
//   clk        in  1             : rising-edge clock
//   reset      in  1             : asynchronous, active-low; clears SP,
//                                  depth and flags (memory is kept)
//   wait_state in  1             : freeze; no state change, no write
//   D          in  WIDTH         : write data
//   delta      in  2             : signed SP adjust (+1, 0, -1, -2)
//   change     in  1             : apply delta
//   update     in  1             : write D at the new SP
//   err_clr    in  1             : clear sticky flags (acts during freeze)
//   Q          out WIDTH         : mem[SP], combinational
//   Q1         out WIDTH         : mem[SP-1], combinational
//   depth      out SADDR_WIDTH+1 : occupancy 0..2**SADDR_WIDTH
//   empty      out 1             : depth == 0
//   full       out 1             : depth == 2**SADDR_WIDTH
//   overflow   out 1             : sticky overflow flag
//   underflow  out 1             : sticky underflow flag
// -----------------------------------------------------------------------------
module stack_guarded
  import stack_pkg::*;
#(
  parameter int SADDR_WIDTH = 8,
  parameter int WIDTH       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wait_state,
  input  logic [WIDTH-1:0]       D,
  input  logic [1:0]             delta,
  input  logic                   change,
  input  logic                   update,
  input  logic                   err_clr,
  output logic [WIDTH-1:0]       Q,
  output logic [WIDTH-1:0]       Q1,
  output logic [SADDR_WIDTH:0]   depth,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int ENTRIES = 1 << SADDR_WIDTH;
  localparam logic [SADDR_WIDTH:0] CAP = {1'b1, {SADDR_WIDTH{1'b0}}};

  logic [WIDTH-1:0]       mem_q [ENTRIES];
  logic [SADDR_WIDTH-1:0] sp_q, sp_d;
  logic [SADDR_WIDTH:0]   depth_q, depth_d;

  logic [SADDR_WIDTH-1:0] sp_n;
  logic [SADDR_WIDTH+1:0] dep_n;
  logic                   ovf_err, udf_err;
  logic                   accept;
  logic                   wr_en;
  logic [SADDR_WIDTH-1:0] sp_m1;

  sp_guard #(
    .SADDR_WIDTH (SADDR_WIDTH)
  ) u_sp_guard (
    .sp      (sp_q),
    .depth   (depth_q),
    .delta   (delta),
    .change  (change),
    .update  (update),
    .sp_n    (sp_n),
    .dep_n   (dep_n),
    .ovf_err (ovf_err),
    .udf_err (udf_err)
  );

  // Depth keeps only its architectural width; in the unguarded build this is
  // exactly the modulo-2**(SADDR_WIDTH+1) wrap. The sign bit is consumed only
  // by the guard inside sp_guard.
  logic unused_dep_sign;
  assign unused_dep_sign = dep_n[SADDR_WIDTH+1];

`ifdef STACK_GUARD_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  assign accept = !wait_state && !ovf_err && !udf_err;

  // Clear first, then set, so a same-cycle set wins. Clearing is not frozen
  // by wait_state; setting is.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (!wait_state && ovf_err) ovf_d = 1'b1;
    if (!wait_state && udf_err) udf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  logic unused_err;
  assign unused_err = ^{ovf_err, udf_err, err_clr};

  assign accept    = !wait_state;
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  // NOTE: every variable assigned in always_comb gets a hold default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sp_d    = sp_q;
    depth_d = depth_q;
    if (accept) begin
      sp_d    = sp_n;
      depth_d = dep_n[SADDR_WIDTH:0];
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q    <= '0;
      depth_q <= '0;
    end else begin
      sp_q    <= sp_d;
      depth_q <= depth_d;
    end
  end

  assign wr_en = accept && update;

  // NOTE: the storage array has no reset so it maps onto plain RAM; a write
  // coinciding with an asserted reset is dropped by the reset term instead.
  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      mem_q[sp_n] <= D;
    end
  end

  assign sp_m1 = sp_q - 1'b1;
  assign Q     = mem_q[sp_q];
  assign Q1    = mem_q[sp_m1];

  assign depth = depth_q;
  assign empty = (depth_q == '0);
  assign full  = (depth_q == CAP);

endmodule : stack_guarded
